// File: rtl/alu_xor_6bit_pkg.sv
// Shared definitions for the 6-bit ALU logic units.
package alu_xor_6bit_pkg;

    localparam int unsigned ALU_W = 6;

    // Status flags produced alongside every logic-unit result
    typedef struct packed {
        logic zero;
        logic parity;
        logic all_ones;
    } alu_flags_t;

    // Flag value matching a cleared (all-zero) result
    localparam alu_flags_t FLAGS_RST = '{zero: 1'b1, parity: 1'b0, all_ones: 1'b0};

endpackage : alu_xor_6bit_pkg

// File: rtl/alu_xor_6bit_flag_gen.sv
// Combinational flag generator shared by the XOR/AND/OR logic units.
module alu_flag_gen
    import alu_xor_6bit_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W
) (
    input  logic [WIDTH-1:0] i_result,
    output alu_flags_t       o_flags_c
);

    // Derive zero / parity / all-ones from the result about to be registered
    always_comb begin
        o_flags_c          = FLAGS_RST;
        o_flags_c.zero     = (i_result == '0);
        o_flags_c.parity   = ^i_result;
        o_flags_c.all_ones = &i_result;
    end

endmodule : alu_flag_gen

// File: rtl/alu_xor_6bit.sv
// Bitwise XOR stage of the 6-bit ALU: registered A ^ B with status flags.
module alu_xor_6bit
    import alu_xor_6bit_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] X,
    output logic             out_valid,
    output logic             zero,
    output logic             parity,
    output logic             all_ones
);

    logic [WIDTH-1:0] w_x;
    alu_flags_t       w_flags;

    logic [WIDTH-1:0] r_x;
    alu_flags_t       r_flags;
    logic             r_out_valid;

    assign w_x = A ^ B;

    // Flags come from the value being captured, so X and flags never disagree
    alu_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .i_result  (w_x),
        .o_flags_c (w_flags)
    );

    // Capture registers: reset wins over in_valid, otherwise hold when idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x         <= '0;
            r_flags     <= FLAGS_RST;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_x     <= w_x;
                r_flags <= w_flags;
            end
        end
    end

    assign X         = r_x;
    assign out_valid = r_out_valid;
    assign zero      = r_flags.zero;
    assign parity    = r_flags.parity;
    assign all_ones  = r_flags.all_ones;

endmodule : alu_xor_6bit

// File: tb/tb_alu_xor_6bit.sv
// Directed self-checking bench for alu_xor_6bit.
module tb_alu_xor_6bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] A;
    logic [5:0] B;
    logic [5:0] X;
    logic       out_valid;
    logic       zero;
    logic       parity;
    logic       all_ones;

    int n_checks = 0;
    int n_fail   = 0;

    alu_xor_6bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .X         (X),
        .out_valid (out_valid),
        .zero      (zero),
        .parity    (parity),
        .all_ones  (all_ones)
    );

    always #5 clk = ~clk;

    // Apply inputs, then step one rising edge and settle 1 time unit past it
    task automatic drive(input logic rn, input logic v, input logic [5:0] a, input logic [5:0] b);
        rst_n    = rn;
        in_valid = v;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 6'b111111, 6'b000000);
        drive(1'b0, 1'b1, 6'b111111, 6'b000000);
        n_checks++;
        if ({X, out_valid, zero, parity, all_ones} !== {6'b000000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: X=%b ov=%b z=%b p=%b ao=%b, want X=000000 ov=0 z=1 p=0 ao=0",
                     X, out_valid, zero, parity, all_ones);
        end
    endtask

    task automatic test_equal();
        drive(1'b1, 1'b1, 6'b101010, 6'b101010);
        n_checks++;
        if ({X, out_valid, zero, parity, all_ones} !== {6'b000000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL equal: X=%b ov=%b z=%b p=%b ao=%b, want X=000000 ov=1 z=1 p=0 ao=0",
                     X, out_valid, zero, parity, all_ones);
        end
    endtask

    task automatic test_partial();
        drive(1'b1, 1'b1, 6'b111111, 6'b101010);
        n_checks++;
        if ({X, out_valid, zero, parity, all_ones} !== {6'b010101, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL partial: X=%b ov=%b z=%b p=%b ao=%b, want X=010101 ov=1 z=0 p=1 ao=0",
                     X, out_valid, zero, parity, all_ones);
        end
        drive(1'b1, 1'b1, 6'b000000, 6'b000000);
        n_checks++;
        if ({X, out_valid, zero, parity, all_ones} !== {6'b000000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL zeros: X=%b ov=%b z=%b p=%b ao=%b, want X=000000 ov=1 z=1 p=0 ao=0",
                     X, out_valid, zero, parity, all_ones);
        end
    endtask

    task automatic test_mixed();
        drive(1'b1, 1'b1, 6'b110100, 6'b010101);
        n_checks++;
        if ({X, out_valid, zero, parity, all_ones} !== {6'b100001, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mixed: X=%b ov=%b z=%b p=%b ao=%b, want X=100001 ov=1 z=0 p=0 ao=0",
                     X, out_valid, zero, parity, all_ones);
        end
        drive(1'b1, 1'b1, 6'b101010, 6'b010101);
        n_checks++;
        if ({X, out_valid, zero, parity, all_ones} !== {6'b111111, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL complement: X=%b ov=%b z=%b p=%b ao=%b, want X=111111 ov=1 z=0 p=0 ao=1",
                     X, out_valid, zero, parity, all_ones);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] va [4];
        logic [5:0] vb [4];
        logic [8:0] vexp [4];   // {X, zero, parity, all_ones}
        va[0] = 6'b000111; vb[0] = 6'b000001; vexp[0] = {6'b000110, 1'b0, 1'b0, 1'b0};
        va[1] = 6'b110000; vb[1] = 6'b000000; vexp[1] = {6'b110000, 1'b0, 1'b0, 1'b0};
        va[2] = 6'b001011; vb[2] = 6'b000000; vexp[2] = {6'b001011, 1'b0, 1'b1, 1'b0};
        va[3] = 6'b111110; vb[3] = 6'b000001; vexp[3] = {6'b111111, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, va[i], vb[i]);
            n_checks++;
            if ({X, zero, parity, all_ones, out_valid} !== {vexp[i], 1'b1}) begin
                n_fail++;
                $display("FAIL b2b[%0d]: X=%b z=%b p=%b ao=%b ov=%b, want {X,z,p,ao}=%b ov=1",
                         i, X, zero, parity, all_ones, out_valid, vexp[i]);
            end
        end
        // Idle cycles with changing or unknown operands must leave the result alone
        drive(1'b1, 1'b0, 6'b000000, 6'b111111);
        drive(1'b1, 1'b0, 6'b101010, 6'bxxxxxx);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({X, zero, parity, all_ones, out_valid} !== {6'b111111, 1'b0, 1'b0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL hold[%0d]: X=%b z=%b p=%b ao=%b ov=%b, want X=111111 z=0 p=0 ao=1 ov=0",
                         i, X, zero, parity, all_ones, out_valid);
            end
            drive(1'b1, 1'b0, 6'bzzzzzz, 6'b010101);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 6'b010101, 6'b000000);
        n_checks++;
        if ({X, out_valid, parity} !== {6'b010101, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_reset: X=%b ov=%b p=%b, want X=010101 ov=1 p=1", X, out_valid, parity);
        end
        drive(1'b0, 1'b1, 6'b111111, 6'b000000);
        n_checks++;
        if ({X, out_valid, zero, parity, all_ones} !== {6'b000000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: X=%b ov=%b z=%b p=%b ao=%b, want X=000000 ov=0 z=1 p=0 ao=0",
                     X, out_valid, zero, parity, all_ones);
        end
        drive(1'b1, 1'b0, 6'b111111, 6'b000000);
        n_checks++;
        if ({X, out_valid, zero} !== {6'b000000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL post_reset: X=%b ov=%b z=%b, want X=000000 ov=0 z=1", X, out_valid, zero);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        test_reset();
        test_equal();
        test_partial();
        test_mixed();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_xor_6bit

// File: doc/alu_xor_6bit.md
Name: alu_xor_6bit

Overview:
Bitwise XOR stage of the 6-bit ALU. Takes two 6-bit operands and produces X = A ^ B, registered, plus status flags. Sits beside the other 6-bit ALU logic units and feeds the result mux and the flag register.

Parameters:
WIDTH, 6, operand/result width in bits; all rules below are stated for WIDTH but the default 6 is the only configuration the ALU uses.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk
in_valid  input  1  A/B are valid this cycle and are to be captured
A  input  WIDTH  operand A
B  input  WIDTH  operand B
X  output  WIDTH  registered result A ^ B
out_valid  output  1  X and flags hold a new result this cycle
zero  output  1  registered: X == 0 (operands equal)
parity  output  1  registered: reduction XOR of X (odd number of differing bits)
all_ones  output  1  registered: X == all ones (A is bitwise complement of B)

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-low: when rst_n is 0 at a rising edge, X <= 0, out_valid <= 0, zero <= 1, parity <= 0, all_ones <= 0. Reset has priority over in_valid. There is no asynchronous path.
- Latency: exactly 1 cycle. If in_valid = 1 at edge N, then after edge N: X = A ^ B (bitwise, per bit X[i] = A[i] ^ B[i]), out_valid = 1, and the flags describe that X.
- Hold: if in_valid = 0 at an edge, X, zero, parity and all_ones hold their previous values, and out_valid <= 0. The result persists until the next capture or reset.
- Back-to-back: in_valid may be high every cycle. Each edge captures new operands, giving full throughput with no bubbles or stalls and no backpressure input.
- Flags are derived from the value being written into X in the same edge, never from the old X. This keeps the flags and X always consistent.
- Width rules: no carry, no overflow, no sign interpretation. Operands are pure bit vectors.
- Reset mid-stream: a capture that coincides with an active reset is discarded, and out_valid is 0 on the following cycle.
- X/Z on inputs with in_valid = 0 must not affect the outputs.

Decomposition:
- Shared ALU package: the WIDTH constant (ALU_W = 6) and a flag struct/bundle {zero, parity, all_ones} reused by the other ALU logic units.
- One natural sub-module: alu_flag_gen. It is combinational, takes a WIDTH result and produces zero, parity and all_ones. The AND/OR units share it.
- The top holds the XOR array, the capture registers and the valid flop.

Test Plan:
- Reset: hold rst_n = 0 for 2 edges with in_valid = 1 and A = 6'b111111 -> X = 6'b000000, out_valid = 0, zero = 1, parity = 0, all_ones = 0.
- Equal operands: A = 6'b101010, B = 6'b101010, in_valid = 1 -> next cycle X = 6'b000000, zero = 1, parity = 0, all_ones = 0, out_valid = 1.
- Partial complement: A = 6'b111111, B = 6'b101010 -> X = 6'b010101, zero = 0, parity = 1, all_ones = 0. Then A = 6'b000000, B = 6'b000000 -> X = 6'b000000, zero = 1.
- Mixed bits: A = 6'b110100, B = 6'b010101 -> X = 6'b100001, parity = 0, zero = 0. Then A = 6'b101010, B = 6'b010101 -> X = 6'b111111, all_ones = 1, parity = 0.
- Hold and back-to-back: drive four captures on consecutive cycles and check each X one cycle later. Then drop in_valid with changing A/B -> X unchanged, out_valid = 0.
- Reset mid-stream: assert rst_n = 0 while in_valid = 1 and A = 6'b111111, B = 6'b000000 -> X = 6'b000000 and out_valid = 0 after that edge, never 6'b111111.
